cc_tailbite_encoder: RTL and testbench
======================================

Name: cc_tailbite_encoder

Overview:
- Rate-1/2, K=7 tail-biting convolutional encoder (generators 171/133 octal).
- Sits directly downstream of the PRBS randomizer and consumes its serial scrambled bit stream.
- Buffers one block of BLOCK_LEN bits and preloads the encoder state with the block's last 6 bits, so the encoder ends in the state it started from.
- Emits one (X,Y) coded pair per input bit to the interleaver/mapper stage.

Parameters:
BLOCK_LEN, 96, uncoded bits per FEC block (legal range 7..256).
CNT_W, 8, width of the bit index counter; must satisfy 2^CNT_W > BLOCK_LEN.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  when low, all state holds and no handshake completes.
data_in  input  1  scrambled bit from the randomizer.
in_valid  input  1  data_in is valid this cycle.
in_ready  output  1  block accepts a bit this cycle.
out_x  output  1  coded bit X (G1=171).
out_y  output  1  coded bit Y (G2=133).
out_valid  output  1  out_x/out_y valid.
out_ready  input  1  downstream accepts the pair this cycle.
out_first  output  1  qualifies the first pair of a block.
out_last  output  1  qualifies the final pair of a block.

Behaviour:
- Reset (async assert, reset=0):
  - state=COLLECT, counter=0, buffer and shift register cleared.
  - in_ready=1, out_valid=0, out_x=out_y=out_first=out_last=0.
  - Reset asserted mid-block discards the partial block and any unsent pairs.
- Bit numbering: b[0] is the first accepted bit of a block, b[N-1] the last (N=BLOCK_LEN).
- Input transfer = enable & in_valid & in_ready.
- Output transfer = enable & out_valid & out_ready.
- COLLECT:
  - in_ready=1, out_valid=0.
  - Each input transfer writes b[cnt] and increments cnt.
  - On the transfer with cnt=N-1: go to LOAD, cnt=0.
- LOAD (exactly 1 cycle when enable=1):
  - in_ready=0.
  - Shift register loads s0=b[N-1], s1=b[N-2], ..., s5=b[N-6] (s0 is the most recent).
  - Go to ENCODE.
- ENCODE:
  - in_ready=0, out_valid=1, u=b[cnt].
  - out_x = u^s0^s1^s2^s5.
  - out_y = u^s1^s2^s4^s5.
  - out_first = (cnt==0); out_last = (cnt==N-1).
  - Outputs are combinational from registered state and stay stable while out_ready=0.
  - On each output transfer: shift {s5..s0} <= {s4..s0,u}, cnt++.
  - On the transfer with cnt=N-1: go to COLLECT, cnt=0. in_ready rises the following cycle.
  - After the last pair, the shift register equals the LOAD value (tail-biting check).
- Latency:
  - The first pair appears 2 cycles after the transfer of b[N-1] (LOAD, then ENCODE visible).
  - Throughput in steady state is one pair per cycle.
  - A block of N bits occupies N + 1 + N cycles minimum.
- enable=0 in any state:
  - Freezes all registers.
  - in_ready and out_valid are forced to 0.
- in_valid while in_ready=0 is ignored; the upstream holds its bit.
- No overlap: the next block is not accepted until the current block is fully emitted.

Test Plan:
1. All-zero block (96 zeros), out_ready=1 -> 96 pairs, all X=0,Y=0; out_first on pair 0, out_last on pair 95; in_ready returns high the cycle after.
2. All-ones block -> tail state 111111; all 96 pairs X=1,Y=1.
3. Impulse b[0]=1, rest 0 -> pairs 0..6: X=1,1,1,1,0,0,1 and Y=1,0,1,1,0,1,1; pairs 7..95 are 00.
4. Impulse b[95]=1, rest 0 (tail wrap) -> pairs 0..5: X=1,1,1,0,0,1 and Y=0,1,1,0,1,1; pairs 6..94 are 00; pair 95 is X=1,Y=1.
5. Random 96-bit block with out_ready toggled pseudo-randomly and enable low for 5 cycles mid-ENCODE -> pair sequence identical to a golden model run with out_ready=1; outputs stable during stalls; no pairs lost or duplicated.
6. Assert reset after 40 input bits, then feed a fresh all-ones block -> no output from the partial block; the second block encodes as in scenario 2. Assert reset at ENCODE pair 50 -> out_valid=0 immediately and in_ready=1.

Source files
------------

// File: rtl/cc_tailbite_encoder_if.sv
// Stream interface for the tail-biting encoder: serial bit input, coded pair output.
interface cc_tailbite_encoder_if;
  logic enable;
  logic data_in;
  logic in_valid;
  logic in_ready;
  logic out_x;
  logic out_y;
  logic out_valid;
  logic out_ready;
  logic out_first;
  logic out_last;

  // Upstream/downstream side (drives the encoder)
  modport master (
    output enable, data_in, in_valid, out_ready,
    input  in_ready, out_x, out_y, out_valid, out_first, out_last
  );

  // Encoder side
  modport slave (
    input  enable, data_in, in_valid, out_ready,
    output in_ready, out_x, out_y, out_valid, out_first, out_last
  );
endinterface

// File: rtl/cc_tailbite_encoder.sv
// Rate-1/2, K=7 tail-biting convolutional encoder (G1=171, G2=133 octal).
// Collects a block of BLOCK_LEN bits, seeds the shift register with the last
// six bits of the block, then emits one (X,Y) pair per buffered bit.
module cc_tailbite_encoder #(
  parameter int BLOCK_LEN = 96,
  parameter int CNT_W     = 8
) (
  input logic                  clk,
  input logic                  reset,
  cc_tailbite_encoder_if.slave bus
);

  localparam int              IDX_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {COLLECT, LOAD, ENCODE} state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [BLOCK_LEN-1:0]   r_buf;
  logic [5:0]             r_sr;     // r_sr[0] is s0, the most recent bit

  logic [IDX_W-1:0]       w_idx;
  logic                   w_u;
  logic                   w_enc;
  logic                   w_x;
  logic                   w_y;

  // The counter never exceeds BLOCK_LEN-1, so its low bits address the buffer.
  assign w_idx = r_cnt[IDX_W-1:0];
  assign w_u   = r_buf[w_idx];
  assign w_enc = (r_state == ENCODE);
  assign w_x   = w_u ^ r_sr[0] ^ r_sr[1] ^ r_sr[2] ^ r_sr[5];
  assign w_y   = w_u ^ r_sr[1] ^ r_sr[2] ^ r_sr[4] ^ r_sr[5];

  // Handshake is gated by enable; data outputs are held while stalled.
  assign bus.in_ready  = bus.enable & (r_state == COLLECT);
  assign bus.out_valid = bus.enable & w_enc;
  assign bus.out_x     = w_enc & w_x;
  assign bus.out_y     = w_enc & w_y;
  assign bus.out_first = w_enc & (r_cnt == '0);
  assign bus.out_last  = w_enc & (r_cnt == LAST);

  // Block controller: collect, seed the shift register with the tail, encode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_sr    <= '0;
    end else if (bus.enable) begin
      unique case (r_state)
        COLLECT: begin
          if (bus.in_valid) begin
            r_buf[w_idx] <= bus.data_in;
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_state <= LOAD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        LOAD: begin
          // Tail-biting seed: s0=b[N-1] ... s5=b[N-6]
          for (int k = 0; k < 6; k++) begin
            r_sr[k] <= r_buf[BLOCK_LEN-1-k];
          end
          r_state <= ENCODE;
        end
        ENCODE: begin
          if (bus.out_ready) begin
            r_sr <= {r_sr[4:0], w_u};
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_state <= COLLECT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_tailbite_encoder.sv
// Self-checking bench for cc_tailbite_encoder against a circular-convolution model.
module tb_cc_tailbite_encoder;
  localparam int N = 96;
  localparam logic [6:0] G1 = 7'o171;
  localparam logic [6:0] G2 = 7'o133;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;
  bit   blk  [N];
  bit   ex_x [N];
  bit   ex_y [N];

  cc_tailbite_encoder_if bus ();

  cc_tailbite_encoder #(.BLOCK_LEN(N), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tail-biting code = circular convolution of the block with each generator;
  // generator MSB taps the current bit, LSB the bit six positions earlier.
  task automatic model();
    for (int i = 0; i < N; i++) begin
      bit x, y, v;
      x = 1'b0;
      y = 1'b0;
      for (int d = 0; d < 7; d++) begin
        v = blk[(i - d + N) % N];
        if (G1[6-d]) x ^= v;
        if (G2[6-d]) y ^= v;
      end
      ex_x[i] = x;
      ex_y[i] = y;
    end
  endtask

  task automatic send_block(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int t;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.data_in  = blk[i];
      #1;
      t = 0;
      while (!bus.in_ready && t < 100) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t >= 100) chk("send_timeout", t, 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic recv_block(input int npairs, input bit rnd, input int gap_at, input bit lat);
    int  k;
    int  t;
    bit  gapped;
    k = 0;
    t = 0;
    gapped = 1'b0;
    while (k < npairs && t < 5000) begin
      @(negedge clk);
      t++;
      if (k == gap_at && !gapped) begin
        gapped = 1'b1;
        bus.enable = 1'b0;
        repeat (5) begin
          #1;
          chk("en_off_valid", bus.out_valid, 0);
          chk("en_off_ready", bus.in_ready, 0);
          @(negedge clk);
        end
        bus.enable = 1'b1;
      end
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (lat && t == 1) chk("lat_load_valid", bus.out_valid, 0);
      if (lat && t == 2) chk("lat_first_valid", bus.out_valid, 1);
      if (bus.out_valid) begin
        chk($sformatf("x[%0d]", k), bus.out_x, ex_x[k]);
        chk($sformatf("y[%0d]", k), bus.out_y, ex_y[k]);
        chk($sformatf("first[%0d]", k), bus.out_first, (k == 0));
        chk($sformatf("last[%0d]", k), bus.out_last, (k == N - 1));
        chk("busy_in_ready", bus.in_ready, 0);
        if (bus.out_ready) begin
          k++;
          if (k == npairs) bus.in_valid = 1'b0;
        end
      end
    end
    if (k < npairs) chk("recv_timeout", k, npairs);
    if (k == N) begin
      @(negedge clk);
      #1;
      chk("done_in_ready", bus.in_ready, 1);
      chk("done_out_valid", bus.out_valid, 0);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_xy"}, {bus.out_x, bus.out_y}, 0);
    chk({tag, "_first_last"}, {bus.out_first, bus.out_last}, 0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset         = 1'b0;
    bus.enable    = 1'b1;
    bus.data_in   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_idle("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // All zeros, with first-pair latency check
    for (int i = 0; i < N; i++) blk[i] = 1'b0;
    model();
    send_block(N);
    recv_block(N, 1'b0, -1, 1'b1);

    // All ones
    for (int i = 0; i < N; i++) blk[i] = 1'b1;
    model();
    send_block(N);
    recv_block(N, 1'b0, -1, 1'b0);

    // Impulse at the first bit
    for (int i = 0; i < N; i++) blk[i] = 1'b0;
    blk[0] = 1'b1;
    model();
    send_block(N);
    recv_block(N, 1'b0, -1, 1'b0);

    // Impulse at the last bit (wraps into the seed)
    blk[0]   = 1'b0;
    blk[N-1] = 1'b1;
    model();
    send_block(N);
    recv_block(N, 1'b0, -1, 1'b0);

    // Random block, random backpressure, enable gap, upstream pushing while busy
    for (int i = 0; i < N; i++) blk[i] = 1'($urandom_range(0, 1));
    model();
    send_block(N);
    bus.in_valid = 1'b1;
    bus.data_in  = 1'($urandom_range(0, 1));
    recv_block(N, 1'b1, 30, 1'b0);

    // Reset after a partial block
    for (int i = 0; i < N; i++) blk[i] = 1'($urandom_range(0, 1));
    send_block(40);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("rst_partial");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) blk[i] = 1'b1;
    model();
    send_block(N);
    recv_block(N, 1'b0, -1, 1'b0);

    // Reset in the middle of encoding
    for (int i = 0; i < N; i++) blk[i] = 1'($urandom_range(0, 1));
    model();
    send_block(N);
    recv_block(50, 1'b1, -1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("rst_encode");
    @(negedge clk);
    reset = 1'b1;

    // Recovery block after mid-encode reset
    for (int i = 0; i < N; i++) blk[i] = 1'($urandom_range(0, 1));
    model();
    send_block(N);
    recv_block(N, 1'b1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
